fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RISC-V core: owns the PC and issues one request at a time to instruction memory.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight and
// presents {pc, instr} to IF/ID, holding it under stall and squashing stale responses on redirect.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;

    logic            slot_free;
    logic            load;
    logic [XLEN-1:0] load_data;
    logic            to_drain;
    logic            unused_redirect_lo;

    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign slot_free      = !if_valid_q || !stall;
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;

    // A redirect must keep draining whenever a response is still owed for the old path.
    assign to_drain = ((state_q == S_WAIT)  && !imem_rsp_valid) ||
                      ((state_q == S_REQ)   &&  imem_req_ready) ||
                      ((state_q == S_DRAIN) && !imem_rsp_valid);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        load       = 1'b0;
        load_data  = hold_q;

        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = imem_rsp_data;
                        state_d   = S_REQ;
                    end else begin
                        hold_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    load      = 1'b1;
                    load_data = hold_q;
                    state_d   = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            load       = 1'b0;
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            if_valid_d = 1'b0;
            hold_d     = '0;
            state_d    = to_drain ? S_DRAIN : S_REQ;
        end

        if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = load_data;
            pc_d       = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            hold_q     <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level imem model plus an in-order
// PC/instruction scoreboard, with directed resets, a held-request redirect and PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, stall, if_valid;
    logic [31:0] redirect_pc, if_pc, if_instr;

    logic        w_reset, w_req_valid, w_req_ready, w_rsp_valid;
    logic [31:0] w_req_addr, w_rsp_data;
    logic        w_redir, w_stall, w_if_valid;
    logic [31:0] w_redir_pc, w_if_pc, w_if_instr;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk(clk), .reset(w_reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc), .stall(w_stall),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model state
    logic [31:0] exp_pc;
    int          consumed, idle;
    bit          outst, outst_stale;
    logic [31:0] outst_addr;
    int          outst_cnt;
    bit          nv_known, nv_exp;
    logic [31:0] nv_pc;
    bit          p_rv, p_rdy, p_redir, p_ifv, p_stall;
    logic [31:0] p_tgt, p_addr, p_ifpc, p_ifi;
    int          p_stall_pct, p_redir_pct, p_nrdy_pct, p_spur_pct, k_max;
    bit          f_redir, f_spur;
    logic [31:0] f_tgt;

    task automatic reset_checks();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
    endtask

    task automatic do_reset(input int n, input bit late);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) reset_checks();
            reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        end
        @(negedge clk);
        reset_checks();
        reset = 1'b0;
        exp_pc = RST_PC; outst = 0; outst_stale = 0; nv_known = 0;
        p_rv = 0; p_ifv = 0; p_redir = 0; idle = 0; f_spur = late;
    endtask

    task automatic cycle();
        logic        s_rv, s_ifv, n_stall, n_redir, n_rdy, n_rspv, real_rsp;
        logic [31:0] s_addr, s_ifpc, s_ifi, n_tgt, n_rspd;
        @(negedge clk);
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_ifv = if_valid; s_ifpc = if_pc; s_ifi = if_instr;

        // Protocol and timing rules for what the previous cycle set up
        if (p_rv && !p_rdy) begin
            chk("req_held", 32'(s_rv), 1);
            chk("req_addr", s_addr, p_redir ? {p_tgt[31:2], 2'b00} : p_addr);
        end
        if (p_ifv && p_stall && !p_redir) begin
            chk("hold_valid", 32'(s_ifv), 1);
            chk("hold_pc", s_ifpc, p_ifpc);
            chk("hold_instr", s_ifi, p_ifi);
        end
        if (p_redir) chk("redir_flush", 32'(s_ifv), 0);
        if (nv_known) begin
            chk("rsp_valid", 32'(s_ifv), 32'(nv_exp));
            if (nv_exp) chk("rsp_pc", s_ifpc, nv_pc);
            nv_known = 0;
        end
        if (s_rv) chk("addr_align", 32'(s_addr[1:0]), 0);

        // Stimulus for this cycle
        n_stall = ($urandom_range(99) < p_stall_pct);
        n_redir = f_redir || ($urandom_range(99) < p_redir_pct);
        n_tgt   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        if (f_redir) n_tgt = f_tgt;
        f_redir = 0;
        n_rdy   = !($urandom_range(99) < p_nrdy_pct);

        // Instruction memory: one response k cycles after each acceptance, noise otherwise
        n_rspv = 1'b0; n_rspd = $urandom; real_rsp = 1'b0;
        if (outst) begin
            outst_cnt--;
            if (outst_cnt == 0) begin
                n_rspv = 1'b1; n_rspd = imem_word(outst_addr); real_rsp = 1'b1;
            end
        end else if (f_spur || ($urandom_range(99) < p_spur_pct)) begin
            n_rspv = 1'b1;
        end
        f_spur = 0;
        if (real_rsp) begin
            if (outst_stale || n_redir || !s_ifv || !n_stall) begin
                nv_known = 1; nv_exp = !(outst_stale || n_redir); nv_pc = outst_addr;
            end
            outst = 0;
        end else if (outst && n_redir) begin
            outst_stale = 1;
        end
        if (s_rv && n_rdy) begin
            chk("one_outst", 32'(outst), 0);
            outst = 1; outst_stale = n_redir; outst_addr = s_addr;
            outst_cnt = $urandom_range(k_max, 1);
        end

        // In-order scoreboard of instructions taken by decode
        if (s_ifv && !n_stall && !n_redir) begin
            chk("if_pc", s_ifpc, exp_pc);
            chk("if_instr", s_ifi, imem_word(exp_pc));
            exp_pc += 32'd4; consumed++; idle = 0;
        end else begin
            idle++;
            if (idle > 300) begin
                chk("progress", 32'(idle), 32'd300);
                idle = 0;
            end
        end
        if (n_redir) exp_pc = {n_tgt[31:2], 2'b00};

        p_rv = s_rv; p_rdy = n_rdy; p_redir = n_redir; p_tgt = n_tgt; p_addr = s_addr;
        p_ifv = s_ifv; p_stall = n_stall; p_ifpc = s_ifpc; p_ifi = s_ifi;

        stall = n_stall; redirect_valid = n_redir; redirect_pc = n_tgt;
        imem_req_ready = n_rdy; imem_rsp_valid = n_rspv; imem_rsp_data = n_rspd;
    endtask

    task automatic set_knobs(input int st, input int rd, input int nr, input int sp, input int k);
        p_stall_pct = st; p_redir_pct = rd; p_nrdy_pct = nr; p_spur_pct = sp; k_max = k;
    endtask

    logic [31:0] w_reqs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] w_ins[$];

    initial begin
        int          c0;
        bit          w_pend;
        logic [31:0] w_pend_addr;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        w_reset = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
        w_redir = 1'b0; w_redir_pc = '0; w_stall = 1'b0;
        consumed = 0; f_redir = 0; f_spur = 0; f_tgt = '0;

        // Clean streaming, one-cycle memory
        set_knobs(0, 0, 0, 0, 1);
        do_reset(2, 0);
        c0 = consumed;
        repeat (30) cycle();
        chk("clean_stream", 32'((consumed - c0) >= 8), 1);

        // Request held for five cycles, redirect on the third
        do_reset(2, 0);
        set_knobs(0, 0, 100, 0, 1);
        cycle(); cycle();
        f_redir = 1; f_tgt = 32'h0000_0102;
        cycle(); cycle(); cycle();
        set_knobs(0, 0, 0, 0, 2);
        c0 = consumed;
        repeat (20) cycle();
        chk("redir_held_progress", 32'(consumed > c0), 1);

        // Randomized mix of stalls, redirects, backpressure, latency and noise
        set_knobs(30, 5, 30, 15, 4);
        repeat (3000) cycle();

        // Reset while a request is outstanding, late response right after release
        set_knobs(0, 0, 0, 0, 4);
        for (int i = 0; i < 60 && !(outst && outst_cnt >= 2); i++) cycle();
        chk("reach_wait", 32'(outst && outst_cnt >= 2), 1);
        do_reset(1, 1);
        c0 = consumed;
        repeat (20) cycle();
        chk("post_reset_progress", 32'(consumed > c0), 1);

        // PC wrap on a second instance
        repeat (2) @(negedge clk);
        w_reset = 1'b0;
        w_pend = 0; w_pend_addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            w_rsp_valid = w_pend;
            w_rsp_data  = imem_word(w_pend_addr);
            w_pend = 0;
            if (w_req_valid) begin
                w_reqs.push_back(w_req_addr);
                w_pend = 1; w_pend_addr = w_req_addr;
            end
            if (w_if_valid) begin
                w_pcs.push_back(w_if_pc);
                w_ins.push_back(w_if_instr);
            end
        end
        chk("wrap_req_count", 32'(w_reqs.size() >= 2), 1);
        chk("wrap_if_count", 32'(w_pcs.size() >= 2), 1);
        if (w_reqs.size() >= 2) begin
            chk("wrap_req0", w_reqs[0], WRAP_PC);
            chk("wrap_req1", w_reqs[1], 32'h0);
        end
        if (w_pcs.size() >= 2) begin
            chk("wrap_pc0", w_pcs[0], WRAP_PC);
            chk("wrap_instr0", w_ins[0], imem_word(WRAP_PC));
            chk("wrap_pc1", w_pcs[1], 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
